// File: rtl/lcd_pkg.sv
// lcd_pkg: shared HD44780 bus timing constants, cycle conversion and FSM state encoding
package lcd_pkg;

    localparam int unsigned CLK_HZ       = 50_000_000;
    localparam int unsigned T_AS_NS      = 60;
    localparam int unsigned T_PW_NS      = 500;
    localparam int unsigned T_LOW_NS     = 500;
    localparam int unsigned T_TIMEOUT_NS = 1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EN_HIGH,
        ST_EN_LOW,
        ST_EVAL
    } lcd_state_e;

    function automatic int unsigned ns_to_cyc(input int unsigned ns);
        return int'((64'(ns) * 64'(CLK_HZ) + 64'd999_999_999) / 64'd1_000_000_000);
    endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// lcd_bus_timer: loadable down-counter with zero flag for LCD bus phase timing
module lcd_bus_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt;

    // count down to zero and hold there until reloaded
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // zero marks the final cycle of the loaded phase
    always_comb begin
        zero = (cnt == '0);
    end

endmodule

// File: rtl/lcd_status_reader.sv
// lcd_status_reader: HD44780 busy-flag/address read cycles with optional poll-until-ready
module lcd_status_reader
    import lcd_pkg::*;
#(
    parameter int T_AS_CYC    = ns_to_cyc(T_AS_NS),
    parameter int T_PW_CYC    = ns_to_cyc(T_PW_NS),
    parameter int T_LOW_CYC   = ns_to_cyc(T_LOW_NS),
    parameter int TIMEOUT_CYC = ns_to_cyc(T_TIMEOUT_NS)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       mode,
    output logic       done,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    output logic       timeout,
    output logic       bus_own,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_data_oe,
    input  logic [7:0] lcd_data_i
);

    if (T_AS_CYC < 1 || T_PW_CYC < 1 || T_LOW_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("lcd_status_reader: every *_CYC parameter must be >= 1");
    end

    localparam int MAX_AP = (T_AS_CYC > T_PW_CYC) ? T_AS_CYC : T_PW_CYC;
    localparam int MAX_C  = (MAX_AP > T_LOW_CYC) ? MAX_AP : T_LOW_CYC;
    localparam int TW     = $clog2(MAX_C + 1);
    localparam int EW     = $clog2(TIMEOUT_CYC + 1);

    lcd_state_e    state;
    lcd_state_e    nxt;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic          mode_r;
    logic [EW-1:0] elapsed;
    logic          elapsed_hit;
    logic          finish;
    logic          tmo_now;
    logic          timeout_r;

    lcd_bus_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_val),
        .zero  (tmr_zero)
    );

    // finish decision made in EVAL from the freshly sampled busy flag
    always_comb begin
        elapsed_hit = (elapsed >= EW'(TIMEOUT_CYC));
        finish      = !mode_r || !busy_flag || elapsed_hit;
        tmo_now     = mode_r && busy_flag && elapsed_hit;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    // next-state: each timed phase advances when the bus timer reaches zero
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:    nxt = req ? ST_SETUP : ST_IDLE;
            ST_SETUP:   nxt = tmr_zero ? ST_EN_HIGH : ST_SETUP;
            ST_EN_HIGH: nxt = tmr_zero ? ST_EN_LOW : ST_EN_HIGH;
            ST_EN_LOW:  nxt = tmr_zero ? ST_EVAL : ST_EN_LOW;
            ST_EVAL:    nxt = finish ? ST_IDLE : ST_SETUP;
            default:    nxt = ST_IDLE;
        endcase
    end

    // outputs and timer reload on entry to each timed phase
    always_comb begin
        tmr_load    = (nxt != state) && (nxt != ST_IDLE) && (nxt != ST_EVAL);
        tmr_val     = (nxt == ST_SETUP)   ? TW'(T_AS_CYC - 1) :
                      (nxt == ST_EN_HIGH) ? TW'(T_PW_CYC - 1) : TW'(T_LOW_CYC - 1);
        bus_own     = (state != ST_IDLE);
        lcd_rw      = bus_own;
        lcd_en      = (state == ST_EN_HIGH);
        lcd_rs      = 1'b0;
        lcd_data_oe = 1'b0;
        done        = (state == ST_EVAL) && finish;
        timeout     = done ? tmo_now : timeout_r;
    end

    // sample DB7..0 on the last EN-high cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_flag <= 1'b1;
            addr_cnt  <= '0;
        end else if (state == ST_EN_HIGH && tmr_zero) begin
            busy_flag <= lcd_data_i[7];
            addr_cnt  <= lcd_data_i[6:0];
        end
    end

    // latch mode at request, run the saturating elapsed counter while active
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r  <= 1'b0;
            elapsed <= '0;
        end else if (state == ST_IDLE && req) begin
            mode_r  <= mode;
            elapsed <= '0;
        end else if (state != ST_IDLE && !elapsed_hit) begin
            elapsed <= elapsed + 1'b1;
        end
    end

    // hold the timeout result from the completing EVAL onwards
    always_ff @(posedge clk) begin
        if (rst)
            timeout_r <= 1'b0;
        else if (done)
            timeout_r <= tmo_now;
    end

endmodule
